// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one-outstanding req/ack fetches into a
// 2-entry FIFO and feeds the IF/ID register; branch/jump redirects flush the stage.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch,
    input  logic [31:0]         br_target,
    input  logic                jump,
    input  logic [31:0]         j_target,
    fetch_unit_if.master        imem,
    output logic [31:0]         if_instr,
    output logic [31:0]         id_instr,
    output logic [31:0]         id_pc4,
    output logic                id_valid
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fifo_entry_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    fifo_entry_t fifo_q [2];
    fifo_entry_t fifo_d [2];
    logic [1:0]  count_q, count_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic        redirect;
    logic [31:0] target;
    logic        push;
    logic        pop;
    logic [1:0]  slot;
    fifo_entry_t head;
    fifo_entry_t incoming;

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    assign redirect = ~stall & (jump | branch);
    assign target   = jump ? j_target : br_target;
    assign push     = (state_q == REQ) & imem.imem_ack & ~redirect;
    assign pop      = ~stall & (count_q != 2'd0);
    assign head     = fifo_q[0];
    assign incoming = '{instr: imem.imem_rdata, pc: addr_q};

    // FIFO occupancy and storage: entry 0 is always the head, a pop shifts down.
    always_comb begin
        // NOTE: every always_comb target gets its hold value first so no path leaves it unassigned (no latch).
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        slot      = count_q - {1'b0, pop};
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                fifo_d[0] = fifo_q[1];
            end
            if (push) begin
                fifo_d[slot[0]] = incoming;
            end
        end
    end

    always_comb begin
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (redirect) begin
            id_instr_d = NOP_INSTR;
            id_pc4_d   = 32'h0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_instr_d = (count_q != 2'd0) ? head.instr : NOP_INSTR;
            id_pc4_d   = head.pc + 32'd4;
            id_valid_d = (count_q != 2'd0);
        end
    end

    // Fetch FSM: a new request is only issued when the FIFO will have room for its word.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d    = target;
                    req_d   = 1'b1;
                    addr_d  = align(target);
                    state_d = REQ;
                end else if (count_d <= 2'd1) begin
                    req_d   = 1'b1;
                    addr_d  = align(pc_q);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    if (redirect) begin
                        pc_d   = target;
                        addr_d = align(target);
                    end else begin
                        pc_d = addr_q + 32'd4;
                        if (count_d <= 2'd1) begin
                            addr_d = addr_q + 32'd4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = DROP;
                end
            end
            DROP: begin
                // The in-flight word belongs to the killed path; reissue at the newest PC.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem.imem_ack) begin
                    addr_d  = align(redirect ? target : pc_q);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            count_q    <= 2'd0;
            // NOTE: the two FIFO entries are reset too; they are tiny and it keeps id_pc4 deterministic.
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= 32'h0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_instr       = (count_q != 2'd0) ? head.instr : NOP_INSTR;
    assign id_instr       = id_instr_q;
    assign id_pc4         = id_pc4_q;
    assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, branch, delayed-ack jump,
// jump priority under stall, mid-request reset and PC wrap, all hand-computed.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] j_target;
    logic [31:0] if_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        ack_auto;
    logic        ack_man;
    int          checks = 0;
    int          errors = 0;

    fetch_unit_if imem ();

    // Memory returns 0xC000_0000 | address, so each word identifies where it came from.
    assign imem.imem_ack   = ack_auto ? imem.imem_req : ack_man;
    assign imem.imem_rdata = 32'hC000_0000 | imem.imem_addr;

    fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .branch    (branch),
        .br_target (br_target),
        .jump      (jump),
        .j_target  (j_target),
        .imem      (imem.master),
        .if_instr  (if_instr),
        .id_instr  (id_instr),
        .id_pc4    (id_pc4),
        .id_valid  (id_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
        check({tag, "_instr"}, id_instr, instr);
        check({tag, "_pc4"}, id_pc4, pc4);
        check({tag, "_valid"}, {31'h0, id_valid}, {31'h0, valid});
    endtask

    task automatic check_bus(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, {31'h0, imem.imem_req}, {31'h0, req});
        check({tag, "_addr"}, imem.imem_addr, addr);
    endtask

    task automatic check_reset(input string tag);
        check_bus(tag, 1'b0, 32'h0);
        check_id(tag, 32'h0, 32'h0, 1'b0);
        check({tag, "_if"}, if_instr, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0;
        br_target = 32'h0; j_target = 32'h0; ack_auto = 1'b1; ack_man = 1'b0;
        tick();
        tick();
        check_reset("rst");
        rst = 1'b0;

        // Zero-wait streaming
        tick(); check_bus("s1", 1'b1, 32'h0);  check("s1_valid", {31'h0, id_valid}, 32'h0);
        tick(); check_bus("s2", 1'b1, 32'h4);  check("s2_if", if_instr, 32'hC000_0000);
        check("s2_valid", {31'h0, id_valid}, 32'h0);
        tick(); check_bus("s3", 1'b1, 32'h8);  check_id("s3", 32'hC000_0000, 32'h4, 1'b1);
        tick(); check_bus("s4", 1'b1, 32'hC);  check_id("s4", 32'hC000_0004, 32'h8, 1'b1);
        tick(); check_bus("s5", 1'b1, 32'h10); check_id("s5", 32'hC000_0008, 32'hC, 1'b1);

        // Stall three cycles: FIFO fills, request drops, buffered words drain in order
        stall = 1'b1;
        tick(); check_bus("st1", 1'b0, 32'h10); check_id("st1", 32'hC000_0008, 32'hC, 1'b1);
        check("st1_if", if_instr, 32'hC000_000C);
        tick(); check("st2_req", {31'h0, imem.imem_req}, 32'h0); check_id("st2", 32'hC000_0008, 32'hC, 1'b1);
        tick(); check("st3_req", {31'h0, imem.imem_req}, 32'h0); check_id("st3", 32'hC000_0008, 32'hC, 1'b1);
        stall = 1'b0;
        tick(); check_bus("sr1", 1'b1, 32'h14); check_id("sr1", 32'hC000_000C, 32'h10, 1'b1);
        tick(); check_bus("sr2", 1'b1, 32'h18); check_id("sr2", 32'hC000_0010, 32'h14, 1'b1);
        tick(); check_bus("sr3", 1'b1, 32'h1C); check_id("sr3", 32'hC000_0014, 32'h18, 1'b1);

        // Taken branch to 0x40 while streaming
        branch = 1'b1; br_target = 32'h40;
        tick(); check_bus("br1", 1'b1, 32'h40); check_id("br1", 32'h0, 32'h0, 1'b0);
        check("br1_if", if_instr, 32'h0);
        branch = 1'b0;
        tick(); check_bus("br2", 1'b1, 32'h44); check("br2_valid", {31'h0, id_valid}, 32'h0);
        check("br2_instr", id_instr, 32'h0);
        tick(); check_bus("br3", 1'b1, 32'h48); check_id("br3", 32'hC000_0040, 32'h44, 1'b1);

        // Delayed ack with a jump to 0x100 while the request is outstanding
        ack_auto = 1'b0; ack_man = 1'b0;
        tick(); check_bus("dj1", 1'b1, 32'h48); check_id("dj1", 32'hC000_0044, 32'h48, 1'b1);
        jump = 1'b1; j_target = 32'h100;
        tick(); check_bus("dj2", 1'b1, 32'h48); check_id("dj2", 32'h0, 32'h0, 1'b0);
        jump = 1'b0;
        tick(); check_bus("dj3", 1'b1, 32'h48);
        ack_man = 1'b1;
        tick(); check_bus("dj4", 1'b1, 32'h100); check("dj4_if", if_instr, 32'h0);
        check("dj4_valid", {31'h0, id_valid}, 32'h0);
        ack_man = 1'b0;
        tick(); check_bus("dj5", 1'b1, 32'h100); check("dj5_if", if_instr, 32'h0);
        ack_auto = 1'b1;
        tick(); check_bus("dj6", 1'b1, 32'h104); check("dj6_valid", {31'h0, id_valid}, 32'h0);
        tick(); check_bus("dj7", 1'b1, 32'h108); check_id("dj7", 32'hC000_0100, 32'h104, 1'b1);

        // Branch and jump under stall: ignored until release, then jump wins
        stall = 1'b1; branch = 1'b1; jump = 1'b1; br_target = 32'h200; j_target = 32'h300;
        tick(); check("pr1_req", {31'h0, imem.imem_req}, 32'h0); check_id("pr1", 32'hC000_0100, 32'h104, 1'b1);
        stall = 1'b0;
        tick(); check_bus("pr2", 1'b1, 32'h300); check_id("pr2", 32'h0, 32'h0, 1'b0);
        branch = 1'b0; jump = 1'b0;
        tick(); check_bus("pr3", 1'b1, 32'h304);
        tick(); check_id("pr4", 32'hC000_0300, 32'h304, 1'b1);

        // Reset mid-request; ack in the first cycle after release is ignored
        ack_auto = 1'b0; ack_man = 1'b0;
        tick(); check_bus("mr1", 1'b1, 32'h308); check_id("mr1", 32'hC000_0304, 32'h308, 1'b1);
        rst = 1'b1;
        #1;
        check_reset("mr_rst");
        tick();
        rst = 1'b0; ack_man = 1'b1;
        tick(); check_bus("mr2", 1'b1, 32'h0); check("mr2_if", if_instr, 32'h0);
        check("mr2_valid", {31'h0, id_valid}, 32'h0);
        ack_auto = 1'b1;
        tick(); check_bus("mr3", 1'b1, 32'h4); check("mr3_if", if_instr, 32'hC000_0000);
        tick(); check_id("mr4", 32'hC000_0000, 32'h4, 1'b1);

        // Unaligned jump target near the top of memory: aligned address, PC wraps to 0
        jump = 1'b1; j_target = 32'hFFFF_FFFE;
        tick(); check_bus("wr1", 1'b1, 32'hFFFF_FFFC);
        jump = 1'b0;
        tick(); check_bus("wr2", 1'b1, 32'h0);
        tick(); check_id("wr3", 32'hFFFF_FFFC, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
